// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multicycle instruction-sequencing controller with memory wait timeout
module multicycle_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  opcode,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        ir_we,
    output logic        pc_we,
    output logic        pc_sel,
    output logic        alu_src,
    output logic [1:0]  alu_op,
    output logic        reg_we,
    output logic [1:0]  wb_sel,
    output logic        illegal,
    output logic        bus_err,
    output logic [2:0]  state_o,
    output logic [31:0] instret
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    typedef enum logic [2:0] {
        C_R   = 3'd0,
        C_I   = 3'd1,
        C_LW  = 3'd2,
        C_SW  = 3'd3,
        C_BEQ = 3'd4,
        C_J   = 3'd5
    } cls_t;

    localparam logic [7:0] TMO = 8'(MEM_TIMEOUT);

    state_t     state, state_nx;
    cls_t       cls, cls_nx;
    logic       cls_legal;
    logic       taken;
    logic [7:0] wait_cnt;
    logic       in_req;
    logic       timeout;

    always_comb begin
        cls_nx    = C_R;
        cls_legal = 1'b1;
        case (opcode)
            7'b0110011: cls_nx = C_R;
            7'b0010011: cls_nx = C_I;
            7'b0000011: cls_nx = C_LW;
            7'b0100011: cls_nx = C_SW;
            7'b1100011: cls_nx = C_BEQ;
            7'b1101111: cls_nx = C_J;
            default:    cls_legal = 1'b0;
        endcase
    end

    assign in_req  = (state == S_FETCH) || (state == S_MEM);
    // The request that would make the count reach the limit is the last one allowed.
    assign timeout = in_req && !mem_ready && ((wait_cnt + 8'd1) == TMO);

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   state_nx = S_FETCH;
            S_FETCH: begin
                if (mem_ready)    state_nx = S_DECODE;
                else if (timeout) state_nx = S_HALT;
            end
            S_DECODE: begin
                if (!cls_legal)        state_nx = S_HALT;
                else if (cls_nx == C_J) state_nx = S_WB;
                else                    state_nx = S_EXEC;
            end
            S_EXEC:   state_nx = ((cls == C_LW) || (cls == C_SW)) ? S_MEM : S_WB;
            S_MEM: begin
                if (mem_ready)    state_nx = S_WB;
                else if (timeout) state_nx = S_HALT;
            end
            S_WB:     state_nx = S_FETCH;
            default:  state_nx = S_HALT;
        endcase
    end

    always_comb begin
        mem_req = 1'b0;
        mem_we  = 1'b0;
        ir_we   = 1'b0;
        pc_we   = 1'b0;
        pc_sel  = 1'b0;
        alu_src = 1'b0;
        alu_op  = 2'b00;
        reg_we  = 1'b0;
        wb_sel  = 2'b00;
        case (state)
            S_FETCH: begin
                mem_req = 1'b1;
                ir_we   = mem_ready;
            end
            S_EXEC: begin
                alu_src = (cls == C_I) || (cls == C_LW) || (cls == C_SW);
                if ((cls == C_R) || (cls == C_I)) alu_op = 2'b10;
                else if (cls == C_BEQ)            alu_op = 2'b01;
                else                              alu_op = 2'b00;
            end
            S_MEM: begin
                mem_req = 1'b1;
                mem_we  = (cls == C_SW);
                alu_src = 1'b1;
                alu_op  = 2'b00;
            end
            S_WB: begin
                pc_we  = 1'b1;
                pc_sel = (cls == C_J) || ((cls == C_BEQ) && taken);
                reg_we = !((cls == C_SW) || (cls == C_BEQ));
                if (cls == C_LW)     wb_sel = 2'b01;
                else if (cls == C_J) wb_sel = 2'b10;
                else                 wb_sel = 2'b00;
            end
            default: ;
        endcase
    end

    assign state_o = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            cls      <= C_R;
            taken    <= 1'b0;
            wait_cnt <= 8'd0;
            instret  <= 32'd0;
            illegal  <= 1'b0;
            bus_err  <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == S_DECODE) cls <= cls_nx;
            if (state == S_EXEC) taken <= (cls == C_BEQ) && zero;
            // Outside the request states the counter idles at zero, so entry always starts fresh.
            if (!in_req || mem_ready) wait_cnt <= 8'd0;
            else                      wait_cnt <= wait_cnt + 8'd1;
            if ((state == S_DECODE) && !cls_legal) illegal <= 1'b1;
            if (timeout) bus_err <= 1'b1;
            if (state == S_WB) instret <= instret + 32'd1;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - scoreboard bench for multicycle_ctrl
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  opcode;
    logic        zero;
    logic        mem_ready;
    logic        mem_req, mem_we, ir_we, pc_we, pc_sel, alu_src, reg_we;
    logic [1:0]  alu_op, wb_sel;
    logic        illegal, bus_err;
    logic [2:0]  state_o;
    logic [31:0] instret;

    always #5 clk = ~clk;

    multicycle_ctrl #(.MEM_TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .ir_we(ir_we), .pc_we(pc_we),
        .pc_sel(pc_sel), .alu_src(alu_src), .alu_op(alu_op), .reg_we(reg_we),
        .wb_sel(wb_sel), .illegal(illegal), .bus_err(bus_err),
        .state_o(state_o), .instret(instret)
    );

    typedef struct {
        logic [6:0]  op;
        logic        z;
        int          fdly;
        int          mdly;
        logic [31:0] ret;
    } exp_t;

    exp_t        sb[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          fdly = 0;
    int          mdly = 0;
    logic [2:0]  prev_state = 3'd0;
    int          cyc_in_state = 0;
    int          lat = 0;
    int          mem_cycles = 0;
    logic [31:0] exp_instret = 32'd0;
    bit          wb_seen = 1'b0;

    logic [6:0] t_op [10] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h63, 7'h6F, 7'h33, 7'h13, 7'h03};
    logic       t_z  [10] = '{1'b0,  1'b1,  1'b0,  1'b0,  1'b1,  1'b0,  1'b0,  1'b1,  1'b0,  1'b1};
    int         t_fd [10] = '{0,     2,     0,     1,     0,     0,     1,     3,     0,     3};
    int         t_md [10] = '{0,     0,     3,     2,     0,     0,     0,     0,     0,     0};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic m_is_mem(input logic [6:0] op);
        return (op == 7'h03) || (op == 7'h23);
    endfunction

    function automatic logic m_alu_src(input logic [6:0] op);
        return (op == 7'h13) || m_is_mem(op);
    endfunction

    function automatic logic [1:0] m_alu_op(input logic [6:0] op);
        if ((op == 7'h33) || (op == 7'h13)) return 2'b10;
        if (op == 7'h63) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic m_pc_sel(input logic [6:0] op, input logic z);
        return (op == 7'h6F) || ((op == 7'h63) && z);
    endfunction

    function automatic logic m_reg_we(input logic [6:0] op);
        return (op == 7'h33) || (op == 7'h13) || (op == 7'h03) || (op == 7'h6F);
    endfunction

    function automatic logic [1:0] m_wb_sel(input logic [6:0] op);
        if (op == 7'h03) return 2'b01;
        if (op == 7'h6F) return 2'b10;
        return 2'b00;
    endfunction

    function automatic int m_lat(input logic [6:0] op, input int fd, input int md);
        if (op == 7'h6F) return 3 + fd;
        if (m_is_mem(op)) return 5 + fd + md;
        return 4 + fd;
    endfunction

    task automatic step();
        exp_t e;
        @(negedge clk);
        if (state_o == prev_state) cyc_in_state++;
        else cyc_in_state = 0;
        prev_state = state_o;
        if ((state_o == 3'd1) && (cyc_in_state == 0)) begin
            lat = 0;
            mem_cycles = 0;
        end else begin
            lat++;
        end
        if (sb.size() > 0) begin
            case (state_o)
                3'd3: begin
                    check("exec_alu_src", alu_src, m_alu_src(sb[0].op));
                    check("exec_alu_op", alu_op, m_alu_op(sb[0].op));
                end
                3'd4: begin
                    mem_cycles++;
                    check("mem_req", mem_req, 1);
                    check("mem_we", mem_we, sb[0].op == 7'h23);
                    check("mem_alu", {alu_src, alu_op}, 3'b100);
                end
                3'd5: begin
                    e = sb.pop_front();
                    check("wb_pc_we", pc_we, 1);
                    check("wb_pc_sel", pc_sel, m_pc_sel(e.op, e.z));
                    check("wb_reg_we", reg_we, m_reg_we(e.op));
                    check("wb_sel", wb_sel, m_wb_sel(e.op));
                    check("wb_instret", instret, e.ret);
                    check("latency", lat + 1, m_lat(e.op, e.fdly, e.mdly));
                    check("mem_cycles", mem_cycles, m_is_mem(e.op) ? e.mdly + 1 : 0);
                    wb_seen = 1'b1;
                end
                default: ;
            endcase
        end else if (state_o == 3'd5) begin
            check("unexpected_wb", 1, 0);
        end
        if (state_o == 3'd1)      mem_ready = (cyc_in_state >= fdly);
        else if (state_o == 3'd4) mem_ready = (cyc_in_state >= mdly);
        else                      mem_ready = 1'($urandom_range(0, 1));
        #1;
        if (state_o == 3'd1) check("fetch_ir_we", ir_we, mem_ready);
    endtask

    task automatic run_instr(input logic [6:0] op, input logic z, input int fd, input int md);
        exp_t e;
        opcode = op;
        zero   = z;
        fdly   = fd;
        mdly   = md;
        e.op = op; e.z = z; e.fdly = fd; e.mdly = md; e.ret = exp_instret;
        sb.push_back(e);
        exp_instret = exp_instret + 32'd1;
        wb_seen = 1'b0;
        for (int i = 0; i < 40 && !wb_seen; i++) step();
        if (!wb_seen) check("wb_reached", 0, 1);
    endtask

    task automatic reset_pulse();
        rst = 1'b0;
        #1;
        check("rst_state", state_o, 0);
        check("rst_strobes", {mem_req, mem_we, pc_we, reg_we, ir_we}, 0);
        check("rst_instret", instret, 0);
        check("rst_sticky", {illegal, bus_err}, 0);
        exp_instret = 32'd0;
        @(negedge clk);
        rst = 1'b1;
        prev_state = 3'd0;
        cyc_in_state = 0;
        #1;
        check("release_idle", state_o, 0);
        check("release_mem_req", mem_req, 0);
    endtask

    initial begin
        int nf;
        rst = 1'b0;
        opcode = 7'h00;
        zero = 1'b0;
        mem_ready = 1'b0;
        repeat (2) @(negedge clk);
        reset_pulse();

        for (int i = 0; i < 8; i++) run_instr(t_op[i], t_z[i], t_fd[i], t_md[i]);

        // SW interrupted by reset while its data request is outstanding
        opcode = 7'h23; zero = 1'b0; fdly = 0; mdly = 255;
        for (int i = 0; i < 10 && !((state_o == 3'd4) && (cyc_in_state == 1)); i++) step();
        check("sw_in_mem", state_o, 4);
        check("sw_mem_we", mem_we, 1);
        reset_pulse();
        fdly = 0;
        step();
        check("fetch_after_release", state_o, 1);
        check("fetch_mem_req", mem_req, 1);
        for (int i = 8; i < 10; i++) run_instr(t_op[i], t_z[i], t_fd[i], t_md[i]);

        opcode = 7'h7F; fdly = 0;
        for (int i = 0; i < 10 && state_o != 3'd6; i++) step();
        check("illegal_halt", state_o, 6);
        check("illegal_flag", {illegal, bus_err}, 2'b10);
        for (int i = 0; i < 5; i++) begin
            step();
            check("halt_hold", state_o, 6);
            check("halt_strobes", {mem_req, pc_we, reg_we, illegal}, 4'b0001);
        end
        check("halt_instret", instret, exp_instret);
        reset_pulse();

        opcode = 7'h33; fdly = 255; nf = 0;
        for (int i = 0; i < 20 && state_o != 3'd6; i++) begin
            step();
            if (state_o == 3'd1) nf++;
        end
        check("tmo_fetch_cycles", nf, 4);
        check("tmo_halt", state_o, 6);
        check("tmo_flags", {bus_err, illegal, mem_req}, 3'b100);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
